prf_valid_list: RTL and testbench
=================================

Name: prf_valid_list

Overview:
- Per-physical-register "value ready" bit vector for the out-of-order core's physical register file (PRF).
- Execute writeback sets an entry valid; retirement frees an entry and clears it.
- The rename stage queries two source tags per cycle to learn whether the operands are ready.
- On branch mispredict, the vector is rebuilt from the retirement RAT (RRAT) free list.

Parameters:
- PRF_SIZE, 64, number of physical registers; matches the codebase `PRF_size.
- PRF_WIDTH, 6, index width, equal to clog2(PRF_SIZE); matches `PRF_width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; clears state immediately when 0.
- ROB_mispredict_in  in  1  mispredict recovery strobe from the ROB.
- RRAT_PRF_FL_in  in  PRF_SIZE  RRAT free list; bit i=1 means PRF i is free at the architectural point.
- ex_wr_idx_in  in  PRF_WIDTH  PRF tag written back by execute this cycle; 0 means no write.
- RAT_rda_idx_in  in  PRF_WIDTH  source-A tag to query.
- RAT_rdb_idx_in  in  PRF_WIDTH  source-B tag to query.
- RRAT_free_PRF_num_in  in  PRF_WIDTH  tag freed at retirement this cycle; 0 means none.
- rda_valid_out  out  1  valid bit for the source-A tag.
- rdb_valid_out  out  1  valid bit for the source-B tag.

Behaviour:
- State is valid[PRF_SIZE-1:0].
- Entry 0 is the null/zero tag:
  - it always reads 1;
  - writes and frees addressed to 0 are ignored.
- Reset (reset==0, asynchronous):
  - valid[i]=0 for every i≥1; valid[0]=1.
  - Outputs follow combinationally; with both read tags at 0, both outputs are 1.
- Each rising edge with reset==1, updates apply in priority order:
  1. If ROB_mispredict_in=1: valid[i] <= ~RRAT_PRF_FL_in[i] for i≥1. ex_wr_idx_in and RRAT_free_PRF_num_in are ignored that cycle.
  2. Otherwise, if RRAT_free_PRF_num_in≠0: clear valid[RRAT_free_PRF_num_in].
  3. Otherwise-path, if ex_wr_idx_in≠0: set valid[ex_wr_idx_in]. If the write and the free target the same index, the set wins.
- Reads are combinational. rdX_valid_out = valid[RAT_rdX_idx_in], or 1 when the tag is 0.
- The bypass (see Optional Feature) applies only when the feature is compiled in.
- Latency:
  - a writeback is visible on outputs the next cycle without bypass, or the same cycle with bypass;
  - mispredict recovery is visible the next cycle.
- Mid-operation reset overrides everything asynchronously.
- No handshakes; every input is sampled each cycle.

Optional Feature:
- PRF_VL_BYPASS_EN defined:
  - when ROB_mispredict_in=0 and ex_wr_idx_in≠0, a read tag equal to ex_wr_idx_in returns 1 in the same cycle (read-after-write forwarding).
  - Bypass is suppressed during mispredict.
- Undefined: reads reflect registered state only.

Decomposition:
- Shared package holds PRF_SIZE, PRF_WIDTH, a prf_idx_t typedef (logic [PRF_WIDTH-1:0]) and the NULL_PRF=0 constant.
- The block has no sub-modules; a single flat module is natural.

Test Plan:
- Reset with all inputs 0 -> both outputs 1 (tag 0). Set rda=1, rdb=2 -> both outputs 0.
- ex_wr=1 on one edge, then ex_wr=2 on the next; then rda=1, rdb=2 -> both outputs 1 after the second edge.
- With 1 and 2 valid: mispredict=1, FL=64'hFFFF_FFFF_FFFF_FFFD -> after the edge, rda(1)=1 and rdb(2)=0. Deassert mispredict -> state holds.
- RRAT_free=5 and ex_wr=5 in the same cycle -> valid[5]=1. Next cycle free=5 only -> valid[5]=0.
- Mispredict with ex_wr=3 -> valid[3] follows ~FL[3] only; the write is dropped.
- With bypass: ex_wr=7 and rda=7 -> rda_valid_out=1 in the same cycle. Without bypass -> 0 until the next edge. Assert reset mid-run -> all entries except 0 read 0 immediately.

Source files
------------

// File: rtl/prf_valid_list_pkg.sv
// Shared definitions for the PRF valid list.
//   PRF_SIZE  : number of physical registers
//   PRF_WIDTH : physical register tag width, clog2(PRF_SIZE)
//   prf_idx_t : physical register tag type
//   NULL_PRF  : reserved tag 0, always reads ready and is never written
package prf_valid_list_pkg;

   localparam int unsigned PRF_SIZE  = 64;
   localparam int unsigned PRF_WIDTH = $clog2(PRF_SIZE);

   typedef logic [PRF_WIDTH-1:0] prf_idx_t;

   localparam prf_idx_t NULL_PRF = '0;

   // Reset image: only the null tag is ready.
   localparam logic [PRF_SIZE-1:0] VALID_RESET = {{(PRF_SIZE-1){1'b0}}, 1'b1};

endpackage

// File: rtl/prf_valid_list.sv
// Per-physical-register "value ready" vector.
//
// Writeback sets an entry, retirement clears it, and a mispredict rebuilds
// the whole vector from the RRAT free list. Two combinational read ports
// serve the rename stage.
//
// Ports:
//   clock                 : system clock, rising edge
//   reset                 : asynchronous active-low reset
//   ROB_mispredict_in     : rebuild strobe from the ROB
//   RRAT_PRF_FL_in        : RRAT free list, bit i = 1 means PRF i is free
//   ex_wr_idx_in          : tag written back this cycle, 0 = none
//   RAT_rda_idx_in        : source-A query tag
//   RAT_rdb_idx_in        : source-B query tag
//   RRAT_free_PRF_num_in  : tag freed at retirement this cycle, 0 = none
//   rda_valid_out         : ready bit for source A
//   rdb_valid_out         : ready bit for source B
//
// Build option: define PRF_VL_BYPASS_EN to forward a same-cycle writeback
// to the read ports (suppressed during mispredict).
module prf_valid_list
   import prf_valid_list_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                ROB_mispredict_in,
   input  logic [PRF_SIZE-1:0] RRAT_PRF_FL_in,
   input  prf_idx_t            ex_wr_idx_in,
   input  prf_idx_t            RAT_rda_idx_in,
   input  prf_idx_t            RAT_rdb_idx_in,
   input  prf_idx_t            RRAT_free_PRF_num_in,
   output logic                rda_valid_out,
   output logic                rdb_valid_out
);

   logic [PRF_SIZE-1:0] valid_q;
   logic [PRF_SIZE-1:0] valid_d;

   logic wr_en;
   logic free_en;

   assign wr_en   = (ex_wr_idx_in != NULL_PRF);
   assign free_en = (RRAT_free_PRF_num_in != NULL_PRF);

   // Next state: mispredict rebuild beats everything; otherwise the free is
   // applied first so that a writeback to the same tag wins.
   always_comb begin
      valid_d = valid_q;
      if (ROB_mispredict_in) begin
         valid_d = ~RRAT_PRF_FL_in;
      end else begin
         if (free_en) begin
            valid_d[RRAT_free_PRF_num_in] = 1'b0;
         end
         if (wr_en) begin
            valid_d[ex_wr_idx_in] = 1'b1;
         end
      end
      // Null tag is pinned ready regardless of the free list.
      valid_d[NULL_PRF] = 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q <= VALID_RESET;
      end else begin
         valid_q <= valid_d;
      end
   end

`ifdef PRF_VL_BYPASS_EN
   logic byp_en;
   assign byp_en = wr_en && !ROB_mispredict_in;
`endif

   always_comb begin
      rda_valid_out = valid_q[RAT_rda_idx_in];
      rdb_valid_out = valid_q[RAT_rdb_idx_in];
      if (RAT_rda_idx_in == NULL_PRF) begin
         rda_valid_out = 1'b1;
      end
      if (RAT_rdb_idx_in == NULL_PRF) begin
         rdb_valid_out = 1'b1;
      end
`ifdef PRF_VL_BYPASS_EN
      if (byp_en && (RAT_rda_idx_in == ex_wr_idx_in)) begin
         rda_valid_out = 1'b1;
      end
      if (byp_en && (RAT_rdb_idx_in == ex_wr_idx_in)) begin
         rdb_valid_out = 1'b1;
      end
`endif
   end

endmodule

// File: tb/tb_prf_valid_list.sv
// Self-checking bench for prf_valid_list: a table of single-edge update
// vectors followed by hand-written bypass and mid-run reset sequences.
module tb_prf_valid_list;
   import prf_valid_list_pkg::*;

`ifdef PRF_VL_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                clock;
   logic                reset;
   logic                misp;
   logic [PRF_SIZE-1:0] fl;
   prf_idx_t            wr;
   prf_idx_t            rda;
   prf_idx_t            rdb;
   prf_idx_t            free_idx;
   logic                va;
   logic                vb;

   int n_cmp;
   int n_err;

   prf_valid_list u_dut (
      .clock                (clock),
      .reset                (reset),
      .ROB_mispredict_in    (misp),
      .RRAT_PRF_FL_in       (fl),
      .ex_wr_idx_in         (wr),
      .RAT_rda_idx_in       (rda),
      .RAT_rdb_idx_in       (rdb),
      .RRAT_free_PRF_num_in (free_idx),
      .rda_valid_out        (va),
      .rdb_valid_out        (vb)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string               name;
      logic                misp;
      logic [PRF_SIZE-1:0] fl;
      prf_idx_t            wr;
      prf_idx_t            free_idx;
      prf_idx_t            rda;
      prf_idx_t            rdb;
      logic                exp_a;
      logic                exp_b;
   } vec_t;

   localparam int NVEC = 15;
   vec_t vec [NVEC];

   task automatic chk(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic clear_updates();
      misp     = 1'b0;
      fl       = '0;
      wr       = '0;
      free_idx = '0;
   endtask

   // Move to just after the next rising edge.
   task automatic edge_step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      clear_updates();
      rda   = '0;
      rdb   = '0;
      reset = 1'b0;

      // name, misp, fl, wr, free, rda, rdb, exp_a, exp_b
      vec[0]  = '{"idle_null",   1'b0, 64'h0, 6'd0,  6'd0,  6'd0,  6'd0,  1'b1, 1'b1};
      vec[1]  = '{"idle_1_2",    1'b0, 64'h0, 6'd0,  6'd0,  6'd1,  6'd2,  1'b0, 1'b0};
      vec[2]  = '{"wr1",         1'b0, 64'h0, 6'd1,  6'd0,  6'd1,  6'd2,  1'b1, 1'b0};
      vec[3]  = '{"wr2",         1'b0, 64'h0, 6'd2,  6'd0,  6'd1,  6'd2,  1'b1, 1'b1};
      vec[4]  = '{"misp_fffd",   1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 6'd0, 6'd0, 6'd1, 6'd2,
                  1'b1, 1'b0};
      vec[5]  = '{"hold",        1'b0, 64'h0, 6'd0,  6'd0,  6'd1,  6'd2,  1'b1, 1'b0};
      vec[6]  = '{"free_wr5",    1'b0, 64'h0, 6'd5,  6'd5,  6'd5,  6'd0,  1'b1, 1'b1};
      vec[7]  = '{"free5",       1'b0, 64'h0, 6'd0,  6'd5,  6'd5,  6'd1,  1'b0, 1'b1};
      vec[8]  = '{"wr3",         1'b0, 64'h0, 6'd3,  6'd0,  6'd3,  6'd3,  1'b1, 1'b1};
      vec[9]  = '{"misp_drop_wr", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 6'd3, 6'd0, 6'd3, 6'd1,
                  1'b0, 1'b0};
      vec[10] = '{"misp_drop_fr", 1'b1, 64'hFFFF_FFFF_FFFF_FFF7, 6'd4, 6'd3, 6'd3, 6'd4,
                  1'b1, 1'b0};
      vec[11] = '{"misp_all",    1'b1, 64'h0, 6'd0,  6'd0,  6'd63, 6'd62, 1'b1, 1'b1};
      vec[12] = '{"free63_wr62", 1'b0, 64'h0, 6'd62, 6'd63, 6'd63, 6'd62, 1'b0, 1'b1};
      vec[13] = '{"free62",      1'b0, 64'h0, 6'd0,  6'd62, 6'd62, 6'd63, 1'b0, 1'b0};
      vec[14] = '{"misp_null_fl", 1'b1, 64'h3, 6'd0, 6'd0,  6'd0,  6'd1,  1'b1, 1'b0};

      // Reset state is visible while reset is still asserted.
      #3;
      chk("rst_a_null", va, 1'b1);
      chk("rst_b_null", vb, 1'b1);
      rda = 6'd1;
      rdb = 6'd2;
      #1;
      chk("rst_a_1", va, 1'b0);
      chk("rst_b_2", vb, 1'b0);
      rda = '0;
      rdb = '0;
      @(negedge clock);
      reset = 1'b1;
      edge_step();

      for (int i = 0; i < NVEC; i++) begin
         misp     = vec[i].misp;
         fl       = vec[i].fl;
         wr       = vec[i].wr;
         free_idx = vec[i].free_idx;
         rda      = vec[i].rda;
         rdb      = vec[i].rdb;
         edge_step();
         clear_updates();
         #1;
         chk({vec[i].name, "_a"}, va, vec[i].exp_a);
         chk({vec[i].name, "_b"}, vb, vec[i].exp_b);
      end

      // Clear everything, then probe same-cycle forwarding.
      misp = 1'b1;
      fl   = '1;
      edge_step();
      clear_updates();
      rda = 6'd7;
      rdb = 6'd8;
      #1;
      chk("byp_base_a", va, 1'b0);

      // Forwarding must be suppressed while a mispredict is in flight.
      misp = 1'b1;
      fl   = '1;
      wr   = 6'd7;
      #1;
      chk("byp_misp_a", va, 1'b0);
      edge_step();
      clear_updates();
      #1;
      chk("byp_misp_after", va, 1'b0);

      wr = 6'd7;
      #1;
      chk("byp_same_a", va, BYP);
      chk("byp_same_b", vb, 1'b0);
      edge_step();
      clear_updates();
      #1;
      chk("byp_next_a", va, 1'b1);
      chk("byp_next_b", vb, 1'b0);

      // Fill the vector, then drop reset between edges.
      misp = 1'b1;
      fl   = '0;
      edge_step();
      clear_updates();
      rda = 6'd7;
      rdb = 6'd63;
      #1;
      chk("pre_rst_a", va, 1'b1);
      chk("pre_rst_b", vb, 1'b1);
      #1;
      reset = 1'b0;
      #1;
      chk("mid_rst_a7", va, 1'b0);
      chk("mid_rst_b63", vb, 1'b0);
      rdb = 6'd0;
      #1;
      chk("mid_rst_b0", vb, 1'b1);
      @(negedge clock);
      reset = 1'b1;
      edge_step();
      #1;
      chk("post_rst_a7", va, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
